// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and sizing for the APB master controller.
// Slave regions are 12 KB windows on a 14 KB stride.
package apb_master_ctrl_pkg;

  localparam int NO_OF_SLAVES      = 16;
  localparam int ADDRESS_WIDTH     = 32;
  localparam int DATA_WIDTH        = 8;
  localparam int SLAVE_MEMORY_SIZE = 12;
  localparam int SLAVE_MEMORY_GAP  = 2;

  typedef enum logic [2:0] {
    PROT_NORMAL      = 3'b000,
    PROT_PRIVILEGED  = 3'b001,
    PROT_NONSECURE   = 3'b010,
    PROT_PRIV_NSEC   = 3'b011,
    PROT_INSTR       = 3'b100,
    PROT_PRIV_INSTR  = 3'b101,
    PROT_NSEC_INSTR  = 3'b110,
    PROT_ALL         = 3'b111
  } protection_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } apb_master_state_e;

endpackage

// File: rtl/apb_master_ctrl_addr_decoder.sv
// Combinational address decode: one-hot slave select plus hit flag.
// Gap bytes between windows and addresses past the last slave miss.
module apb_addr_decoder
  import apb_master_ctrl_pkg::*;
#(
  parameter int N_SLV  = NO_OF_SLAVES,
  parameter int ADDR_W = ADDRESS_WIDTH
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_SLV-1:0]  sel,
  output logic              hit
);

  localparam logic [63:0] STRIDE =
    64'((SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP) * 1024);
  localparam logic [63:0] WIN = 64'(SLAVE_MEMORY_SIZE * 1024);

  logic [63:0] w_addr;
  logic [63:0] w_base;

  always_comb begin
    sel    = '0;
    w_addr = 64'(addr);
    w_base = '0;
    for (int i = 0; i < N_SLV; i++) begin
      w_base = STRIDE * 64'(unsigned'(i));
      if (w_addr >= w_base && w_addr < w_base + WIN)
        sel[i] = 1'b1;
    end
    hit = |sel;
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: request/response front end driving a decoded APB bus
// with wait-state counting and an ACCESS-phase timeout.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int NO_OF_SLAVES   = apb_master_ctrl_pkg::NO_OF_SLAVES,
  parameter int ADDRESS_WIDTH  = apb_master_ctrl_pkg::ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = apb_master_ctrl_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   req_strb,
  input  logic [2:0]                req_prot,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic [7:0]                rsp_wait_states,
  output logic [ADDRESS_WIDTH-1:0]  paddr,
  output logic [NO_OF_SLAVES-1:0]   pselx,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  apb_master_state_e r_state, w_state_nxt;

  logic [NO_OF_SLAVES-1:0]  w_sel;
  logic                     w_hit;
  logic                     w_accept;
  logic                     w_expire;

  logic [NO_OF_SLAVES-1:0]  r_sel;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic                     r_write;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH/8-1:0]  r_strb;
  protection_type_e         r_prot;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_slverr;
  logic                     r_timeout;
  logic [7:0]               r_wait;

  apb_addr_decoder #(
    .N_SLV  (NO_OF_SLAVES),
    .ADDR_W (ADDRESS_WIDTH)
  ) u_dec (
    .addr (req_addr),
    .sel  (w_sel),
    .hit  (w_hit)
  );

  assign req_ready = (r_state == IDLE) & preset_n;
  assign w_accept  = req_valid & req_ready;
  assign w_expire  = ~pready & (r_wait == TO_LAST);

  always_ff @(posedge pclk) begin
    if (!preset_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:   if (w_accept) w_state_nxt = w_hit ? SETUP : RESP;
      SETUP:  w_state_nxt = ACCESS;
      ACCESS: if (pready || w_expire) w_state_nxt = RESP;
      RESP:   if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_sel     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_prot    <= PROT_NORMAL;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
      r_wait    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rdata   <= '0;
            r_timeout <= 1'b0;
            r_wait    <= '0;
            r_slverr  <= ~w_hit;
            if (w_hit) begin
              r_sel   <= w_sel;
              r_addr  <= req_addr;
              r_write <= req_write;
              r_wdata <= req_write ? req_wdata : '0;
              r_strb  <= req_write ? req_strb : '0;
              r_prot  <= protection_type_e'(req_prot);
            end
          end
        end
        ACCESS: begin
          if (pready) begin
            r_rdata  <= r_write ? '0 : prdata;
            r_slverr <= pslverr;
          end else begin
            if (r_wait != 8'hFF) r_wait <= r_wait + 8'd1;
            if (w_expire) begin
              r_timeout <= 1'b1;
              r_slverr  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus strobes come straight from state so reset drops them at once.
  assign pselx   = (r_state == SETUP || r_state == ACCESS) ? r_sel : '0;
  assign penable = (r_state == ACCESS);
  assign paddr   = r_addr;
  assign pwrite  = r_write;
  assign pwdata  = r_wdata;
  assign pstrb   = r_strb;
  assign pprot   = r_prot;

  assign rsp_valid       = (r_state == RESP);
  assign rsp_rdata       = r_rdata;
  assign rsp_slverr      = r_slverr;
  assign rsp_timeout     = r_timeout;
  assign rsp_wait_states = r_wait;

endmodule
